display_scan_controller: RTL and testbench

Time-multiplexing scheduler for the clock's common-anode seven-segment bank. It divides `clkM` into fixed digit slots and walks the anodes one digit at a time, inserting a blanking gap at each switch to prevent ghosting. It decodes BCD to segments with optional leading-zero suppression and per-digit blinking. The time/date datapath hands it new digit values through a frame-synchronous load handshake, so a display update never tears mid-frame.

---
 rtl/display_scan_controller.sv | 142 ++++++++++++++
 tb/tb_display_scan_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Digit scan scheduler for a common-anode seven-segment bank: slot timing with blanking gaps,
// BCD decode, leading-zero suppression, blinking, and a frame-synchronous digit load handshake.
module display_scan_controller #(
  parameter int M            = 10_000_000,
  parameter int SCAN_HZ      = 500,
  parameter int DIGITS       = 4,
  parameter int BLANK_CYC    = 200,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clkM,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  output logic                  load_ack,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_start
);

  // state   | meaning
  // S_BLANK | slot cycles 0..BLANK_CYC-1, all anodes off
  // S_DRIVE | slot cycles BLANK_CYC..P-1, anode idx on

  localparam int P  = M / SCAN_HZ;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(P - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [FW-1:0]         fcnt, fcnt_n;
  logic                  phase, phase_n;
  logic [4*DIGITS-1:0]   shadow, shadow_n;
  logic [DIGITS-1:0]     an_n;
  logic [6:0]            seg_n;
  logic                  fb;
  logic                  lz_blank;
  logic                  bl_blank;
  logic [3:0]            dig;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clkM) begin
    if (clr) begin
      state       <= S_BLANK;
      cnt         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      phase       <= 1'b0;
      shadow      <= '0;
      an          <= '1;
      seg         <= 7'h7F;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      fcnt        <= fcnt_n;
      phase       <= phase_n;
      shadow      <= shadow_n;
      an          <= an_n;
      seg         <= seg_n;
      load_ack    <= fb & load;
      frame_start <= fb;
    end
  end

  // Outputs are registered, so they are derived from the next-cycle state.
  always_comb begin
    fb       = (cnt == CNT_LAST) && (idx == IDX_LAST);
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    fcnt_n   = fcnt;
    phase_n  = phase;
    shadow_n = shadow;
    state_n  = state;
    an_n     = '1;
    seg_n    = 7'h7F;

    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    if (fb) begin
      if (load) shadow_n = digits_in;
      if (fcnt == FRM_LAST) begin
        fcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        fcnt_n = fcnt + 1'b1;
      end
    end

    case (state)
      S_BLANK: if (cnt == BLANK_LAST) state_n = S_DRIVE;
      S_DRIVE: if (cnt == CNT_LAST)   state_n = S_BLANK;
      default: state_n = S_BLANK;
    endcase

    dig      = shadow_n[{idx_n, 2'b00} +: 4];
    // Digit 0 is never suppressed; higher digits only when they and all above are zero.
    lz_blank = lz_en && (idx_n != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx_n)) && (shadow_n[4*i +: 4] != 4'd0)) lz_blank = 1'b0;
    end
    bl_blank = blink_mask[idx_n] & phase_n;

    if (state_n == S_DRIVE) begin
      an_n[idx_n] = 1'b0;
      if (!(lz_blank || bl_blank)) seg_n = decode(dig);
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with P=10, 4 digits, 2 blank cycles, 2 frames per blink phase.
module tb_display_scan_controller;

  logic        clkM = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  blink_mask = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  int checks = 0;
  int failures = 0;
  int tcur = 0;

  display_scan_controller #(
    .M(1000), .SCAN_HZ(100), .DIGITS(4), .BLANK_CYC(2), .BLINK_FRAMES(2)
  ) dut (
    .clkM(clkM), .clr(clr), .digits_in(digits_in), .load(load), .load_ack(load_ack),
    .blink_mask(blink_mask), .lz_en(lz_en), .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clkM = ~clkM;

  task automatic tick();
    @(posedge clkM);
    #1;
    tcur++;
  endtask

  task automatic goto(input int t);
    while (tcur < t) tick();
  endtask

  // Returns 1 ns after the last clr edge; that cycle is t=0.
  task automatic do_reset();
    clr = 1'b1;
    repeat (3) @(posedge clkM);
    #1;
    clr = 1'b0;
    tcur = 0;
  endtask

  task automatic test_reset();
    digits_in = '0; load = 0; lz_en = 0; blink_mask = '0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an t=%0d got=%b exp=1111", tcur, an); end
      checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg t=%0d got=%h exp=7f", tcur, seg); end
      checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL reset_ack t=%0d got=%b exp=0", tcur, load_ack); end
      tick();
    end
    checks++; if (an !== 4'b1110) begin failures++; $display("FAIL reset_an_t2 got=%b exp=1110", an); end
    checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL reset_seg_t2 got=%h exp=40", seg); end
    while (tcur < 40) begin
      checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs_early t=%0d got=%b exp=0", tcur, frame_start); end
      tick();
    end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL reset_fs_t40 got=%b exp=1", frame_start); end
    tick();
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs_t41 got=%b exp=0", frame_start); end
  endtask

  task automatic test_scan();
    logic [6:0] segtab [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int s, slot, c;
    segtab[0] = 7'h19; segtab[1] = 7'h30; segtab[2] = 7'h24; segtab[3] = 7'h79;
    do_reset();
    digits_in = 16'h1234; load = 1;
    goto(40);
    load = 0;
    while (tcur < 120) begin
      s = (tcur - 40) % 40; slot = s / 10; c = s % 10;
      exp_an = 4'hF; exp_seg = 7'h7F;
      if (c >= 2) begin exp_an[slot] = 1'b0; exp_seg = segtab[slot]; end
      checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an t=%0d got=%b exp=%b", tcur, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL scan_seg t=%0d got=%h exp=%h", tcur, seg, exp_seg); end
      checks++; if ($countones(~an) > 1) begin failures++; $display("FAIL scan_onehot t=%0d got=%b exp=at_most_one_low", tcur, an); end
      checks++; if (load_ack !== (tcur == 40)) begin failures++; $display("FAIL scan_ack t=%0d got=%b exp=%b", tcur, load_ack, (tcur == 40)); end
      tick();
    end
  endtask

  task automatic test_load();
    do_reset();
    digits_in = 16'h0987; load = 0;
    while (tcur <= 80) begin
      checks++; if (load_ack !== (tcur == 40)) begin failures++; $display("FAIL load_ack t=%0d got=%b exp=%b", tcur, load_ack, (tcur == 40)); end
      if (tcur == 2) begin
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL load_old_seg got=%h exp=40", seg); end
      end
      if (tcur == 41) begin
        checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin failures++; $display("FAIL load_gap got=%b/%h exp=1111/7f", an, seg); end
      end
      if (tcur == 42) begin
        checks++; if (an !== 4'b1110) begin failures++; $display("FAIL load_an got=%b exp=1110", an); end
        checks++; if (seg !== 7'h78) begin failures++; $display("FAIL load_seg got=%h exp=78", seg); end
      end
      if (tcur == 13) load = 1;
      if (tcur == 40) load = 0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    digits_in = 16'h1111; load = 1;
    while (tcur <= 84) begin
      checks++; if (load_ack !== (tcur == 40 || tcur == 80)) begin failures++; $display("FAIL b2b_ack t=%0d got=%b exp=%b", tcur, load_ack, (tcur == 40 || tcur == 80)); end
      if (tcur == 42) begin
        checks++; if (seg !== 7'h79) begin failures++; $display("FAIL b2b_seg1 got=%h exp=79", seg); end
      end
      if (tcur == 82) begin
        checks++; if (seg !== 7'h24) begin failures++; $display("FAIL b2b_seg2 got=%h exp=24", seg); end
      end
      if (tcur == 40) digits_in = 16'h2222;
      if (tcur == 80) load = 0;
      tick();
    end
  endtask

  task automatic test_lz();
    do_reset();
    lz_en = 1; digits_in = 16'h0005; load = 1;
    goto(40);
    checks++; if (load_ack !== 1'b1) begin failures++; $display("FAIL lz_ack1 got=%b exp=1", load_ack); end
    digits_in = 16'h0000;
    goto(42); checks++; if (an !== 4'b1110 || seg !== 7'h12) begin failures++; $display("FAIL lz5_d0 got=%b/%h exp=1110/12", an, seg); end
    goto(52); checks++; if (an !== 4'b1101 || seg !== 7'h7F) begin failures++; $display("FAIL lz5_d1 got=%b/%h exp=1101/7f", an, seg); end
    goto(62); checks++; if (an !== 4'b1011 || seg !== 7'h7F) begin failures++; $display("FAIL lz5_d2 got=%b/%h exp=1011/7f", an, seg); end
    goto(72); checks++; if (an !== 4'b0111 || seg !== 7'h7F) begin failures++; $display("FAIL lz5_d3 got=%b/%h exp=0111/7f", an, seg); end
    goto(80);
    checks++; if (load_ack !== 1'b1) begin failures++; $display("FAIL lz_ack2 got=%b exp=1", load_ack); end
    digits_in = 16'h0105;
    goto(82);  checks++; if (an !== 4'b1110 || seg !== 7'h40) begin failures++; $display("FAIL lz0_d0 got=%b/%h exp=1110/40", an, seg); end
    goto(92);  checks++; if (an !== 4'b1101 || seg !== 7'h7F) begin failures++; $display("FAIL lz0_d1 got=%b/%h exp=1101/7f", an, seg); end
    goto(112); checks++; if (an !== 4'b0111 || seg !== 7'h7F) begin failures++; $display("FAIL lz0_d3 got=%b/%h exp=0111/7f", an, seg); end
    goto(120);
    checks++; if (load_ack !== 1'b1) begin failures++; $display("FAIL lz_ack3 got=%b exp=1", load_ack); end
    load = 0;
    goto(122); checks++; if (an !== 4'b1110 || seg !== 7'h12) begin failures++; $display("FAIL lz105_d0 got=%b/%h exp=1110/12", an, seg); end
    goto(132); checks++; if (an !== 4'b1101 || seg !== 7'h40) begin failures++; $display("FAIL lz105_d1 got=%b/%h exp=1101/40", an, seg); end
    goto(142); checks++; if (an !== 4'b1011 || seg !== 7'h79) begin failures++; $display("FAIL lz105_d2 got=%b/%h exp=1011/79", an, seg); end
    goto(152); checks++; if (an !== 4'b0111 || seg !== 7'h7F) begin failures++; $display("FAIL lz105_d3 got=%b/%h exp=0111/7f", an, seg); end
    lz_en = 0;
    goto(155); checks++; if (an !== 4'b0111 || seg !== 7'h40) begin failures++; $display("FAIL lzoff_d3 got=%b/%h exp=0111/40", an, seg); end
  endtask

  task automatic test_blink();
    logic [6:0] exp_seg;
    do_reset();
    digits_in = '0; load = 0; lz_en = 0; blink_mask = 4'b0001;
    for (int f = 0; f < 8; f++) begin
      goto(40*f + 5);
      exp_seg = (((f / 2) % 2) == 1) ? 7'h7F : 7'h40;
      checks++; if (an !== 4'b1110) begin failures++; $display("FAIL blink_an f=%0d got=%b exp=1110", f, an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL blink_seg f=%0d got=%h exp=%h", f, seg, exp_seg); end
      if (f == 2) begin
        goto(95);
        checks++; if (an !== 4'b1101 || seg !== 7'h40) begin failures++; $display("FAIL blink_other got=%b/%h exp=1101/40", an, seg); end
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    digits_in = 16'h1234; load = 1;
    goto(40);
    checks++; if (load_ack !== 1'b1) begin failures++; $display("FAIL mid_ack_pre got=%b exp=1", load_ack); end
    goto(42);
    checks++; if (seg !== 7'h19) begin failures++; $display("FAIL mid_seg_pre got=%h exp=19", seg); end
    goto(57);
    clr = 1; load = 0;
    tick();
    clr = 0; tcur = 0;
    checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin failures++; $display("FAIL mid_t0 got=%b/%h exp=1111/7f", an, seg); end
    tick();
    checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin failures++; $display("FAIL mid_t1 got=%b/%h exp=1111/7f", an, seg); end
    tick();
    checks++; if (an !== 4'b1110 || seg !== 7'h40) begin failures++; $display("FAIL mid_t2 got=%b/%h exp=1110/40", an, seg); end
    while (tcur <= 45) begin
      checks++; if (load_ack !== 1'b0) begin failures++; $display("FAIL mid_noack t=%0d got=%b exp=0", tcur, load_ack); end
      if (tcur == 40) begin
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL mid_fs got=%b exp=1", frame_start); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_lz();
    test_blink();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
